// File: rtl/stage2_decode.sv
// Decode stage: splits the instruction word, reads the register file with
// write-port bypass, detects load-use hazards and registers the result.
module stage2_decode (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] ir_i,
  input  logic [29:0] pc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_reg_i,
  input  logic [31:0] wb_data_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [29:0] pc_o,
  output logic [3:0]  op_o,
  output logic [3:0]  alu_op_o,
  output logic [3:0]  rd_o,
  output logic [31:0] ra_data_o,
  output logic [31:0] rb_data_o,
  output logic [31:0] imm_o,
  output logic [29:0] branch_pc_o,
  output logic        illegal_o
);

  localparam logic [3:0] OP_ALU_R  = 4'd0;
  localparam logic [3:0] OP_LOAD   = 4'd2;
  localparam logic [3:0] OP_STORE  = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_FIRST_ILLEGAL = 4'd6;

  // Handshake: stall_o=1 tells fetch to present the same ir_i/pc_i again next
  // cycle; when it is 0 the current ir_i is consumed at the rising edge.
  logic [31:0] rf [16];
  logic        in_valid;

  logic [3:0]  f_op, f_alu, f_rd, f_ra, f_rb;
  logic [31:0] f_imm;
  logic [29:0] f_bpc;
  logic        uses_ra, uses_rb, hazard;
  logic [31:0] ra_val, rb_val;

  assign f_op  = ir_i[31:28];
  assign f_alu = ir_i[27:24];
  assign f_rd  = ir_i[23:20];
  assign f_ra  = ir_i[19:16];
  assign f_rb  = ir_i[15:12];
  assign f_imm = {{16{ir_i[15]}}, ir_i[15:0]};
  assign f_bpc = pc_i + 30'd1 + f_imm[29:0];

  assign uses_ra = (f_op <= OP_BRANCH);
  assign uses_rb = (f_op == OP_ALU_R) || (f_op == OP_STORE) || (f_op == OP_BRANCH);

  // r0 is hardwired to zero; a same-cycle write wins over the stored value.
  always_comb begin
    ra_val = rf[f_ra];
    rb_val = rf[f_rb];
    if (wb_we_i && (wb_reg_i == f_ra)) ra_val = wb_data_i;
    if (wb_we_i && (wb_reg_i == f_rb)) rb_val = wb_data_i;
    if (f_ra == 4'd0) ra_val = 32'd0;
    if (f_rb == 4'd0) rb_val = 32'd0;
  end

  assign hazard = valid_o && (op_o == OP_LOAD) && (rd_o != 4'd0) &&
                  ((uses_ra && (f_ra == rd_o)) || (uses_rb && (f_rb == rd_o)));

  assign stall_o = hazard || stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) in_valid <= 1'b0;
    else       in_valid <= 1'b1;
  end

  // Register-file writes are independent of reset, stall, flush and hazard.
  always_ff @(posedge clk_i) begin
    if (wb_we_i && (wb_reg_i != 4'd0)) rf[wb_reg_i] <= wb_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o     <= 1'b0;
      illegal_o   <= 1'b0;
      pc_o        <= '0;
      op_o        <= '0;
      alu_op_o    <= '0;
      rd_o        <= '0;
      ra_data_o   <= '0;
      rb_data_o   <= '0;
      imm_o       <= '0;
      branch_pc_o <= '0;
    end else if (flush_i) begin
      valid_o   <= 1'b0;
      illegal_o <= 1'b0;
    end else if (stall_i) begin
      valid_o   <= valid_o;
    end else if (hazard) begin
      valid_o   <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      valid_o     <= in_valid;
      illegal_o   <= in_valid && (f_op >= OP_FIRST_ILLEGAL);
      pc_o        <= pc_i;
      op_o        <= f_op;
      alu_op_o    <= f_alu;
      rd_o        <= f_rd;
      ra_data_o   <= ra_val;
      rb_data_o   <= rb_val;
      imm_o       <= f_imm;
      branch_pc_o <= f_bpc;
    end
  end

endmodule

// File: tb/tb_stage2_decode.sv
// Bench for stage2_decode: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_stage2_decode;

  logic        clk = 1'b0;
  logic        rst, stall, flush, wb_we;
  logic [31:0] ir, wb_data;
  logic [29:0] pc;
  logic [3:0]  wb_reg;
  logic        stall_o, valid_o, illegal_o;
  logic [29:0] pc_o, branch_pc_o;
  logic [3:0]  op_o, alu_op_o, rd_o;
  logic [31:0] ra_data_o, rb_data_o, imm_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  stage2_decode dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .ir_i(ir), .pc_i(pc), .wb_we_i(wb_we), .wb_reg_i(wb_reg),
    .wb_data_i(wb_data), .stall_o(stall_o), .valid_o(valid_o),
    .pc_o(pc_o), .op_o(op_o), .alu_op_o(alu_op_o), .rd_o(rd_o),
    .ra_data_o(ra_data_o), .rb_data_o(rb_data_o), .imm_o(imm_o),
    .branch_pc_o(branch_pc_o), .illegal_o(illegal_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        v, ill;
    logic [29:0] pc, bpc;
    logic [3:0]  op, alu, rd;
    logic [31:0] ra, rb, imm;
  } out_t;

  out_t        m_out;
  logic        m_in_valid;
  logic [31:0] m_rf [16];

  function automatic logic [31:0] m_read(input int idx);
    if (idx == 0) return 32'd0;
    if (wb_we && int'(wb_reg) == idx) return wb_data;
    return m_rf[idx];
  endfunction

  function automatic bit m_hazard();
    int op, ra, rb;
    op = int'(ir[31:28]); ra = int'(ir[19:16]); rb = int'(ir[15:12]);
    if (!(m_out.v && m_out.op == 4'd2 && m_out.rd != 4'd0)) return 1'b0;
    if (op <= 4 && ra == int'(m_out.rd)) return 1'b1;
    if ((op == 0 || op == 3 || op == 4) && rb == int'(m_out.rd)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    out_t nx;
    longint sx;
    nx = m_out;
    if (rst) begin
      nx = '{default: '0};
    end else if (flush) begin
      nx.v = 1'b0; nx.ill = 1'b0;
    end else if (stall) begin
      nx = m_out;
    end else if (m_hazard()) begin
      nx.v = 1'b0; nx.ill = 1'b0;
    end else begin
      sx      = longint'($signed(ir[15:0]));
      nx.v    = m_in_valid;
      nx.ill  = m_in_valid && (ir[31:28] >= 4'd6);
      nx.pc   = pc;
      nx.op   = ir[31:28];
      nx.alu  = ir[27:24];
      nx.rd   = ir[23:20];
      nx.ra   = m_read(int'(ir[19:16]));
      nx.rb   = m_read(int'(ir[15:12]));
      nx.imm  = 32'(sx);
      nx.bpc  = 30'((longint'(pc) + 1 + sx) % (longint'(1) << 30));
    end
    m_out      = nx;
    m_in_valid = !rst;
    if (wb_we && wb_reg != 4'd0) m_rf[wb_reg] = wb_data;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid", 32'(valid_o), 32'(m_out.v));
      check("illegal", 32'(illegal_o), 32'(m_out.ill));
      check("stall_o", 32'(stall_o), 32'(m_hazard() || stall));
      if (m_out.v) begin
        check("pc_o", 32'(pc_o), 32'(m_out.pc));
        check("op_o", 32'(op_o), 32'(m_out.op));
        check("alu_op_o", 32'(alu_op_o), 32'(m_out.alu));
        check("rd_o", 32'(rd_o), 32'(m_out.rd));
        check("ra_data_o", ra_data_o, m_out.ra);
        check("rb_data_o", rb_data_o, m_out.rb);
        check("imm_o", imm_o, m_out.imm);
        check("branch_pc_o", 32'(branch_pc_o), 32'(m_out.bpc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit hold;
    logic [3:0] op;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; wb_we = 1'b0;
    ir = '0; pc = '0; wb_reg = '0; wb_data = '0;
    m_out = '{default: '0};
    m_in_valid = 1'b0;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    tick();
    tick();
    // Register writes land even while reset is held.
    for (int i = 1; i < 16; i++) begin
      wb_we = 1'b1; wb_reg = 4'(i); wb_data = $urandom;
      tick();
    end
    wb_we = 1'b1; wb_reg = 4'd0; wb_data = 32'hFFFF_FFFF;
    tick();
    cmp_en = 1'b1;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_illegal", 32'(illegal_o), 32'd0);
    check("rst_pc", 32'(pc_o), 32'd0);
    check("rst_imm", imm_o, 32'd0);
    check("rst_bpc", 32'(branch_pc_o), 32'd0);
    check("rst_ra", ra_data_o, 32'd0);

    // Reset release: first cycle is always a bubble.
    rst = 1'b0; wb_we = 1'b0; ir = 32'h1350_0007; pc = 30'h10;
    tick();
    check("rel_c1_valid", 32'(valid_o), 32'd0);
    tick();
    check("rel_c2_valid", 32'(valid_o), 32'd1);
    check("rel_c2_rd", 32'(rd_o), 32'd5);
    check("rel_c2_imm", imm_o, 32'd7);
    check("rel_c2_ra", ra_data_o, 32'd0);
    check("rel_c2_op", 32'(op_o), 32'd1);

    // Same-cycle write bypass.
    wb_we = 1'b1; wb_reg = 4'd2; wb_data = 32'hDEAD_BEEF; ir = 32'h0012_0000;
    tick();
    check("bypass_ra", ra_data_o, 32'hDEAD_BEEF);
    wb_we = 1'b0;

    // Load-use hazard: one bubble, then the consumer issues.
    ir = 32'h2030_0004;
    tick();
    check("load_op", 32'(op_o), 32'd2);
    ir = 32'h0043_0000;
    #1;
    check("hazard_stall", 32'(stall_o), 32'd1);
    tick();
    check("bubble_valid", 32'(valid_o), 32'd0);
    check("bubble_stall", 32'(stall_o), 32'd0);
    tick();
    check("after_valid", 32'(valid_o), 32'd1);
    check("after_rd", 32'(rd_o), 32'd4);

    // Branch target wraps modulo 2^30.
    ir = 32'h4000_FFFF; pc = 30'h3FFF_FFFF;
    tick();
    check("br_bpc", 32'(branch_pc_o), 32'h3FFF_FFFF);
    check("br_imm", imm_o, 32'hFFFF_FFFF);

    // Flush wins over stall; an illegal op is suppressed.
    ir = 32'h7000_0000; flush = 1'b1; stall = 1'b1;
    tick();
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_illegal", 32'(illegal_o), 32'd0);
    flush = 1'b0; stall = 1'b0;
    tick();
    check("illegal_valid", 32'(valid_o), 32'd1);
    check("illegal_flag", 32'(illegal_o), 32'd1);

    // Randomized traffic; fetch re-presents the instruction after a stall.
    hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        op = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(6, 15));
        ir = {op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
              4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 12'($urandom)};
        pc = 30'($urandom);
      end
      flush   = ($urandom_range(0, 9) == 0);
      stall   = ($urandom_range(0, 6) == 0);
      wb_we   = $urandom_range(0, 1) != 0;
      wb_reg  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      wb_data = $urandom;
      rst     = ($urandom_range(0, 99) == 0);
      #1;
      hold = stall_o;
      tick();
    end
    rst = 1'b0; flush = 1'b0; stall = 1'b0; wb_we = 1'b0;
    tick();
    tick();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage2_decode.md
STAGE2_DECODE -- requirements
Module: stage2_decode

Interface
REQ-001 SHALL have ports: clk_i  in  1  clock; all state changes on rising edge.
REQ-002 SHALL have ports: rst_i  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: stall_i  in  1  downstream stall; hold all output registers.
REQ-004 SHALL have ports: flush_i  in  1  branch taken in execute; discard current instruction.
REQ-005 SHALL have ports: ir_i  in  32  instruction word from fetch.
REQ-006 SHALL have ports: pc_i  in  30  word address of ir_i.
REQ-007 SHALL have ports: wb_we_i  in  1, wb_reg_i  in  4, wb_data_i  in  32  register-file write port.
REQ-008 SHALL have ports: stall_o  out  1  combinational stall to fetch.
REQ-009 SHALL have registered ports: valid_o 1, pc_o 30, op_o 4, alu_op_o 4, rd_o 4, ra_data_o 32, rb_data_o 32, imm_o 32, branch_pc_o 30, illegal_o 1.

Function
REQ-010 SHALL decode fields: op=ir[31:28], alu_op=ir[27:24], rd=ir[23:20], ra=ir[19:16], rb=ir[15:12], imm16=ir[15:0].
REQ-011 SHALL define op classes: 0 ALU-reg, 1 ALU-imm, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP; 6-15 illegal.
REQ-012 SHALL use ra for ops 0-4, rb for ops 0, 3, 4.
REQ-013 SHALL output imm_o = imm16 sign-extended to 32 bits.
REQ-014 SHALL output branch_pc_o = pc_i + 1 + sign-extended imm16, modulo 2^30.
REQ-015 SHALL contain a 16x32 register file with r0 reading zero; writes to r0 ignored.
REQ-016 SHALL bypass a same-cycle write: wb_we_i with wb_reg_i equal to a nonzero read index returns wb_data_i.
REQ-017 SHALL keep an internal in_valid flop, 0 in reset, 1 from the first cycle after reset deasserts; ir_i is ignored while in_valid=0.
REQ-018 SHALL detect load-use hazard when valid_o=1 and op_o=2 and rd_o!=0 and rd_o matches a used source field of ir_i.
REQ-019 SHALL drive stall_o = hazard OR stall_i.
REQ-020 SHALL update outputs each cycle with priority: flush_i, then stall_i, then hazard, then normal.
REQ-021 flush_i SHALL set valid_o=0 next cycle, also when stall_i=1.
REQ-022 stall_i (no flush) SHALL hold all registered outputs unchanged.
REQ-023 hazard (no flush, no stall_i) SHALL set valid_o=0 (bubble); the same instruction re-arrives next cycle.
REQ-024 normal SHALL register decoded fields with valid_o=in_valid; latency ir_i to outputs = 1 cycle.
REQ-025 SHALL set illegal_o=1 with valid_o=1 for ops 6-15; other fields pass through undecoded.
REQ-026 When valid_o=0, all other outputs are don't-care except illegal_o=0.
REQ-027 Register-file writes SHALL occur regardless of stall_i, flush_i or hazard.

Reset
REQ-028 rst_i SHALL clear valid_o, illegal_o, in_valid and all other registered outputs to 0.
REQ-029 rst_i SHALL NOT clear register-file contents; r0 still reads 0.
REQ-030 rst_i asserted mid-operation SHALL override flush_i, stall_i and hazard the same cycle.
REQ-031 The first cycle after reset SHALL produce valid_o=0 regardless of ir_i.

Verification
REQ-032 Reset release, ir_i=0x1_3_5_0_0007 (ALU-imm op1 alu3 rd5 ra0) -> cycle 1 valid_o=0; cycle 2 valid_o=1, rd_o=5, imm_o=7, ra_data_o=0.
REQ-033 Write r2=0xDEADBEEF via wb same cycle ir_i reads ra=2 -> ra_data_o=0xDEADBEEF next cycle.
REQ-034 LOAD rd=3, then ALU-reg ra=3 -> stall_o=1 one cycle, bubble valid_o=0, then ALU valid_o=1.
REQ-035 BRANCH at pc_i=0x3FFFFFFF, imm16=0xFFFF -> branch_pc_o=0x3FFFFFFF; imm_o=0xFFFFFFFF.
REQ-036 flush_i and stall_i together with op 7 -> valid_o=0, illegal_o=0 next cycle.
